mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, the number of OWN-state cycles allowed before a grant is forcibly revoked (range 1..15).
REQ-002 Parameter: CNT_W, default 4, the width of the hold counter; it SHALL satisfy 2^CNT_W > TIMEOUT.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  3  level requests; req[i] is held high by requester i until it is served or withdraws.
REQ-006 Port: done  input  1  single-cycle pulse from the shared resource marking transaction complete.
REQ-007 Port: grant  output  3  one-hot grant, registered; 000 when no owner.
REQ-008 Port: select  output  2  registered select code for the shared 3:1 mux; 00/01/10 = owner 0/1/2; 11 = no owner, which zeroes the mux output.
REQ-009 Port: busy  output  1  high while in OWN.
REQ-010 Port: timeout_err  output  1  registered one-cycle pulse on forced revocation.

Function
REQ-011 The FSM SHALL have two states: IDLE and OWN.
REQ-012 IDLE with req != 000: the next edge SHALL enter OWN, latch the winner into grant/select, and clear the hold counter.
- Latency: req sampled at edge n gives grant visible after edge n.
REQ-013 Winner: round-robin over pointer p (the last owner).
- Search order: p+1, p+2, p (mod 3); the first asserted req wins.
REQ-014 In OWN:
- grant and select SHALL remain stable.
- The hold counter SHALL increment by 1 per cycle and saturate, with no wrap.
REQ-015 OWN with done=1: the next edge SHALL go to IDLE, clear grant to 000, set select=11, and set p=owner.
REQ-016 OWN with req[owner]=0 and done=0: the next edge SHALL go to IDLE as in REQ-015, with no error.
REQ-017 OWN with the counter at TIMEOUT-1, done=0 and req[owner]=1: the next edge SHALL go to IDLE with p=owner and timeout_err=1 for exactly one cycle.
REQ-018 Priority when events coincide in one cycle:
- done beats timeout (no error).
- done beats withdrawal (same result).
REQ-019 done SHALL be ignored in IDLE.
REQ-020 Changes to req[j] for j != owner SHALL not affect OWN.
REQ-021 OWN SHALL always return to IDLE for at least one cycle, so there is no back-to-back grant.
REQ-022 grant SHALL never have more than one bit set, and select SHALL always equal the encoding of grant.
REQ-023 All outputs SHALL be driven directly from registers, with no combinational path from req or done.

Reset
REQ-024 When rst_n=0, immediately and without a clock edge:
- state = IDLE, grant = 000, select = 11, busy = 0, timeout_err = 0
- counter = 0, p = 2, so req[0] has first priority
REQ-025 Reset asserted during OWN SHALL abort the transaction silently, with no timeout_err.
REQ-026 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with req != 000.

Verification
REQ-027 Reset scenario: drive rst_n=0 mid-cycle during OWN with owner 1 -> grant=000, select=11 and busy=0 before the next edge; after release, with req=111, the first grant is 001.
REQ-028 Single requester scenario: req=010 held, done pulsed 3 cycles after grant -> grant=010 and select=01 one edge after req; grant=000 and select=11 on the edge after done.
REQ-029 Fairness scenario: req=111 constant, done pulsed 2 cycles after each grant -> owner sequence 0,1,2,0,1 with one IDLE cycle between grants.
REQ-030 Timeout scenario: req=100 held, done never asserted -> grant=100 for exactly 15 cycles, then timeout_err=1 for 1 cycle and grant=000; with req=101 thereafter, the next owner is 0.
REQ-031 Coincident events scenario: done coincides with the timeout cycle -> release with timeout_err=0. Withdrawal case: req[owner] drops after 2 cycles -> release with no error, and p advances.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that hands one shared memory port to one of three requesters.
// A grant ends on done, on withdrawal of the owner's request, or when the hold limit expires.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] grant,
    output logic [1:0] select,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [1:0]       SEL_NONE = 2'b11;
    localparam logic [1:0]       PTR_RST  = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Next requester index in round-robin order; the illegal code folds back to 0.
    function automatic logic [1:0] idx_next(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    function automatic logic req_bit(input logic [2:0] r, input logic [1:0] idx);
        logic bit_v;
        case (idx)
            2'd0:    bit_v = r[0];
            2'd1:    bit_v = r[1];
            2'd2:    bit_v = r[2];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       select_q, select_d;
    logic             busy_q, busy_d;
    logic             terr_q, terr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [1:0]       cand1_s, cand2_s, cand3_s;
    logic [1:0]       win_idx_s;
    logic             win_valid_s;
    logic             own_req_s;

    // Round-robin winner search starting just after the last owner.
    always_comb begin
        cand1_s     = idx_next(ptr_q);
        cand2_s     = idx_next(cand1_s);
        cand3_s     = idx_next(cand2_s);
        win_idx_s   = cand3_s;
        win_valid_s = 1'b0;
        if (req_bit(req, cand1_s)) begin
            win_idx_s   = cand1_s;
            win_valid_s = 1'b1;
        end else if (req_bit(req, cand2_s)) begin
            win_idx_s   = cand2_s;
            win_valid_s = 1'b1;
        end else if (req_bit(req, cand3_s)) begin
            win_idx_s   = cand3_s;
            win_valid_s = 1'b1;
        end else begin
            win_idx_s   = cand3_s;
            win_valid_s = 1'b0;
        end
    end

    // Owner's own request; other requesters are deliberately ignored while a grant is held.
    always_comb begin
        own_req_s = req_bit(req, select_q);
    end

    // Next-state and output logic; release checks are ordered so done wins over timeout.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        busy_d   = busy_q;
        terr_d   = 1'b0;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_d  = ST_OWN;
                    grant_d  = idx_onehot(win_idx_s);
                    select_d = win_idx_s;
                    busy_d   = 1'b1;
                    cnt_d    = CNT_ZERO;
                end else begin
                    grant_d  = 3'b000;
                    select_d = SEL_NONE;
                    busy_d   = 1'b0;
                end
            end
            ST_OWN: begin
                if (done || !own_req_s || (cnt_q == CNT_LAST)) begin
                    state_d  = ST_IDLE;
                    grant_d  = 3'b000;
                    select_d = SEL_NONE;
                    busy_d   = 1'b0;
                    cnt_d    = CNT_ZERO;
                    ptr_d    = select_q;
                    terr_d   = !done && own_req_s;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = 3'b000;
                select_d = SEL_NONE;
                busy_d   = 1'b0;
                cnt_d    = CNT_ZERO;
                ptr_d    = PTR_RST;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= 3'b000;
            select_q <= SEL_NONE;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
            cnt_q    <= CNT_ZERO;
            ptr_q    <= PTR_RST;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            busy_q   <= busy_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign select      = select_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: an ownership-level model checked every cycle,
// plus literal expectations taken from the scenario descriptions.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 15;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic       done;
    logic [2:0] grant;
    logic [1:0] select;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .select     (select),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: who owns the port, for how many cycles, and who owned it last.
    typedef struct {
        int owner;
        int p;
        int held;
        int terr;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t s, input logic [2:0] r, input logic d);
        mstate_t n;
        n = s;
        n.terr = 0;
        if (s.owner < 0) begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (s.p + k) % 3;
                if (r[c] && n.owner < 0) begin
                    n.owner = c;
                    n.held  = 1;
                end
            end
        end else if (d || !r[s.owner]) begin
            n.p     = s.owner;
            n.owner = -1;
            n.held  = 0;
        end else if (s.held >= TIMEOUT) begin
            n.p     = s.owner;
            n.owner = -1;
            n.held  = 0;
            n.terr  = 1;
        end else begin
            n.held = s.held + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{owner: -1, p: 2, held: 0, terr: 0};
        end else begin
            m <= model_next(m, req, done);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("model_grant", int'(grant), (m.owner < 0) ? 0 : (1 << m.owner));
        check("model_select", int'(select), (m.owner < 0) ? 3 : m.owner);
        check("model_busy", int'(busy), (m.owner < 0) ? 0 : 1);
        check("model_timeout_err", int'(timeout_err), m.terr);
    endtask

    // Apply one input vector across a rising edge, then compare against the model.
    task automatic step(input logic [2:0] r, input logic d);
        req  = r;
        done = d;
        @(negedge clk);
        cmp_model();
    endtask

    int owners [5];
    int exp_owners [5];
    int held_cnt;

    initial begin
        exp_owners = '{1, 2, 4, 1, 2};
        req   = 3'b000;
        done  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("por_grant", int'(grant), 0);
        check("por_select", int'(select), 3);
        check("por_busy", int'(busy), 0);
        check("por_terr", int'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b000, 1'b0);
        check("idle_no_req", int'(grant), 0);

        // Single requester, done three cycles after grant.
        step(3'b010, 1'b0);
        check("single_grant", int'(grant), 2);
        check("single_select", int'(select), 1);
        step(3'b010, 1'b0);
        step(3'b010, 1'b0);
        step(3'b010, 1'b1);
        check("single_rel_grant", int'(grant), 0);
        check("single_rel_select", int'(select), 3);
        step(3'b000, 1'b0);

        // Reset mid-cycle while owner 1 holds the port.
        step(3'b010, 1'b0);
        check("pre_rst_grant", int'(grant), 2);
        #3 rst_n = 1'b0;
        #1;
        check("rst_grant", int'(grant), 0);
        check("rst_select", int'(select), 3);
        check("rst_busy", int'(busy), 0);
        check("rst_terr", int'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness with all three requesting; done two cycles after each grant.
        for (int g = 0; g < 5; g++) begin
            step(3'b111, 1'b0);
            owners[g] = int'(grant);
            step(3'b111, 1'b0);
            step(3'b111, 1'b1);
            check("fair_gap_busy", int'(busy), 0);
        end
        for (int g = 0; g < 5; g++) begin
            check("fair_owner", owners[g], exp_owners[g]);
        end
        check("fair_first_after_rst", owners[0], 1);

        // Timeout: owner 2 never sees done.
        step(3'b100, 1'b0);
        held_cnt = 0;
        for (int c = 0; c < 20 && grant == 3'b100; c++) begin
            held_cnt++;
            step(3'b100, 1'b0);
        end
        check("to_held_cycles", held_cnt, 15);
        check("to_err_pulse", int'(timeout_err), 1);
        check("to_grant_clear", int'(grant), 0);
        step(3'b101, 1'b0);
        check("to_err_one_cycle", int'(timeout_err), 0);
        check("to_next_owner", int'(grant), 1);
        step(3'b101, 1'b1);

        // done lands on the timeout cycle: release without error.
        step(3'b100, 1'b0);
        check("co_grant", int'(grant), 4);
        for (int c = 0; c < 14; c++) begin
            step(3'b100, 1'b0);
        end
        check("co_still_owned", int'(grant), 4);
        step(3'b100, 1'b1);
        check("co_release", int'(grant), 0);
        check("co_no_err", int'(timeout_err), 0);

        // Withdrawal after two cycles; other requesters do not disturb ownership.
        step(3'b011, 1'b0);
        check("wd_grant", int'(grant), 1);
        step(3'b011, 1'b0);
        step(3'b010, 1'b0);
        check("wd_release", int'(grant), 0);
        check("wd_no_err", int'(timeout_err), 0);
        step(3'b010, 1'b0);
        check("wd_p_advanced", int'(grant), 2);
        step(3'b111, 1'b0);
        step(3'b110, 1'b0);
        check("other_req_ignored", int'(grant), 2);
        step(3'b010, 1'b1);
        step(3'b000, 1'b1);
        check("done_in_idle", int'(busy), 0);
        step(3'b000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
